// File: rtl/coeff_rf_pkg.sv
// Shared constants and state type for the coefficient RF readback and load paths.
// Row layout is {spin_polarity[49:0], part2[127:0], part1[127:0]}.
package coeff_rf_pkg;

    localparam int unsigned NUM_ROWS      = 50;
    localparam int unsigned ROW_W         = 306;
    localparam int unsigned BYTES_PER_ROW = 39;
    localparam int unsigned RD_LAT        = 1;
    localparam int unsigned RF_ADDR_W     = 6;
    localparam int unsigned BYTE_CNT_W    = 6;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        SHIFT,
        DONE
    } rb_state_t;

endpackage

// File: rtl/coefficient_rf_readback_serializer.sv
// Serializes one captured RF row MSB-first into bytes over a valid/ready stage.
// The final byte of a row carries only the two leftover bits, zero-extended.
module rf_row_serializer
    import coeff_rf_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             clr,
    input  logic             load,
    input  logic [ROW_W-1:0] row_data,
    input  logic             ready,
    output logic [7:0]       data,
    output logic             valid,
    output logic             last
);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_ROW - 1);

    logic [ROW_W-1:0]      sr;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic                  valid_q;
    logic                  xfer;
    logic                  is_last;

    assign xfer    = valid_q & ready;
    assign is_last = (byte_cnt == LAST_BYTE);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sr       <= '0;
            byte_cnt <= '0;
            valid_q  <= 1'b0;
        end else if (clr) begin
            sr       <= '0;
            byte_cnt <= '0;
            valid_q  <= 1'b0;
        end else if (load) begin
            sr       <= row_data;
            byte_cnt <= '0;
            valid_q  <= 1'b1;
        end else if (xfer) begin
            if (is_last) begin
                byte_cnt <= '0;
                valid_q  <= 1'b0;
            end else begin
                sr       <= sr << 8;
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    // After 38 shifts the original sr[1:0] sits in the top two bits.
    always_comb begin
        data = '0;
        if (valid_q) begin
            if (is_last) data = {6'b0, sr[ROW_W-1 -: 2]};
            else         data = sr[ROW_W-1 -: 8];
        end
    end

    assign valid = valid_q;
    assign last  = xfer & is_last;

endmodule

// File: rtl/coefficient_rf_readback.sv
// Dumps all coefficient RF rows to the host GPIO byte stream in loader order.
// Owns the RF read sequencing; byte serialization lives in rf_row_serializer.
module coefficient_rf_readback
    import coeff_rf_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 conf_sys_ctrl_reg_RESET,
    input  logic                 conf_sys_ctrl_reg_READBACK,
    input  logic                 conf_sys_ctrl_reg_INIT,
    input  logic                 conf_sys_ctrl_reg_LOAD,
    output logic                 rb_rd_en,
    output logic [RF_ADDR_W-1:0] rb_rd_a,
    input  logic [127:0]         coefficient_rf_part1_q,
    input  logic [127:0]         coefficient_rf_part2_q,
    input  logic [49:0]          spin_polarity_q,
    output logic [7:0]           out_GPIO_data,
    output logic                 out_GPIO_valid,
    input  logic                 in_GPIO_ready,
    output logic                 readback_busy,
    output logic                 readback_done
);

    localparam int unsigned            LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0]       LAT_LAST = LAT_W'(RD_LAT - 1);
    localparam logic [RF_ADDR_W-1:0]   LAST_ROW = RF_ADDR_W'(NUM_ROWS - 1);

    rb_state_t            state, next_state;
    logic                 reset_q, readback_q;
    logic                 soft_rst, start, abort, busy_state;
    logic [LAT_W-1:0]     lat_cnt;
    logic                 lat_last;
    logic [RF_ADDR_W-1:0] row;
    logic                 done_q;
    logic                 ser_last;

    assign soft_rst   = conf_sys_ctrl_reg_RESET & ~reset_q;
    assign busy_state = (state == RD_REQ) || (state == RD_WAIT) || (state == SHIFT);
    assign start      = (state == IDLE) & conf_sys_ctrl_reg_READBACK & ~readback_q
                      & ~conf_sys_ctrl_reg_INIT & ~conf_sys_ctrl_reg_LOAD;
    assign abort      = busy_state & (~conf_sys_ctrl_reg_READBACK
                      | conf_sys_ctrl_reg_INIT | conf_sys_ctrl_reg_LOAD);
    assign lat_last   = (state == RD_WAIT) && (lat_cnt == LAT_LAST);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            reset_q    <= 1'b0;
            readback_q <= 1'b0;
        end else begin
            reset_q    <= conf_sys_ctrl_reg_RESET;
            readback_q <= conf_sys_ctrl_reg_READBACK;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)       state <= IDLE;
        else if (soft_rst) state <= IDLE;
        else               state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = RD_REQ;
            RD_REQ:  next_state = RD_WAIT;
            RD_WAIT: if (lat_last) next_state = SHIFT;
            SHIFT:   if (ser_last) next_state = (row == LAST_ROW) ? DONE : RD_REQ;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    always_comb begin
        rb_rd_en      = (state == RD_REQ);
        rb_rd_a       = (state == RD_REQ) ? row : '0;
        readback_busy = busy_state;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)                      lat_cnt <= '0;
        else if (soft_rst || !busy_state) lat_cnt <= '0;
        else if (state != RD_WAIT)        lat_cnt <= '0;
        else                              lat_cnt <= lat_cnt + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)                               row <= '0;
        else if (soft_rst || abort || start)       row <= '0;
        else if (ser_last && (row != LAST_ROW))    row <= row + 1'b1;
    end

    // Sticky until the next accepted start or any reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)                    done_q <= 1'b0;
        else if (soft_rst || start)     done_q <= 1'b0;
        else if (next_state == DONE)    done_q <= 1'b1;
    end

    assign readback_done = done_q;

    rf_row_serializer u_serializer (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .clr      (soft_rst | abort),
        .load     (lat_last),
        .row_data ({spin_polarity_q, coefficient_rf_part2_q, coefficient_rf_part1_q}),
        .ready    (in_GPIO_ready),
        .data     (out_GPIO_data),
        .valid    (out_GPIO_valid),
        .last     (ser_last)
    );

endmodule

// File: tb/tb_coefficient_rf_readback.sv
// Scoreboard bench for coefficient_rf_readback: stimulus queues expected bytes,
// a negedge monitor pops and compares on every valid/ready transfer.
module tb_coefficient_rf_readback;

    localparam int TOTAL = 1950;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         rst_sys = 1'b0;
    logic         readback = 1'b0;
    logic         init = 1'b0;
    logic         load = 1'b0;
    logic         rd_en;
    logic [5:0]   rd_a;
    logic [127:0] p1_q = '0;
    logic [127:0] p2_q = '0;
    logic [49:0]  spin_q = '0;
    logic [7:0]   gdata;
    logic         gvalid;
    logic         gready = 1'b0;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xfer_count = 0;
    int last_xfer_cyc = 0;
    int start_cyc = 0;
    int rd_en_count = 0;
    int rd_row_exp = 0;
    bit hold_en = 1'b1;
    bit rand_ready = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] exp_q[$];
    logic [7:0] cap[0:TOTAL-1];
    int         xfer_cyc[0:TOTAL-1];

    coefficient_rf_readback dut (
        .i_clk                      (clk),
        .i_rstn                     (rstn),
        .conf_sys_ctrl_reg_RESET    (rst_sys),
        .conf_sys_ctrl_reg_READBACK (readback),
        .conf_sys_ctrl_reg_INIT     (init),
        .conf_sys_ctrl_reg_LOAD     (load),
        .rb_rd_en                   (rd_en),
        .rb_rd_a                    (rd_a),
        .coefficient_rf_part1_q     (p1_q),
        .coefficient_rf_part2_q     (p2_q),
        .spin_polarity_q            (spin_q),
        .out_GPIO_data              (gdata),
        .out_GPIO_valid             (gvalid),
        .in_GPIO_ready              (gready),
        .readback_busy              (busy),
        .readback_done              (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RF model, one-cycle read latency: row r holds part1=r, part2=~r, spin=1.
    always @(posedge clk) begin
        if (rd_en) begin
            p1_q   <= 128'(rd_a);
            p2_q   <= ~(128'(rd_a));
            spin_q <= 50'h1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) gready = 1'($urandom_range(0, 1));
    end

    function automatic logic [7:0] exp_byte(input int r, input int b);
        logic [127:0] p;
        logic [305:0] v;
        p = 128'(r);
        v = {50'h1, ~p, p};
        if (b < 38) return v[305 - 8*b -: 8];
        return {6'b0, v[1:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rd_en) begin
            chk("rd_addr", 64'(rd_a), 64'(rd_row_exp));
            rd_row_exp++;
            rd_en_count++;
        end
        if (hold_en && prev_stall) begin
            chk("stall_valid", 64'(gvalid), 64'd1);
            chk("stall_data", 64'(gdata), 64'(prev_data));
        end
        prev_stall = gvalid && !gready;
        prev_data  = gdata;
        if (gvalid && gready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", 64'(gdata), 64'hxx);
            end else begin
                chk("byte", 64'(gdata), 64'(exp_q.pop_front()));
            end
            if (xfer_count < TOTAL) begin
                cap[xfer_count]      = gdata;
                xfer_cyc[xfer_count] = cyc;
            end
            xfer_count++;
            last_xfer_cyc = cyc;
        end
    end

    task automatic start_dump(input bit push);
        xfer_count = 0;
        rd_row_exp = 0;
        if (push)
            for (int r = 0; r < 50; r++)
                for (int b = 0; b < 39; b++)
                    exp_q.push_back(exp_byte(r, b));
        readback  = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        bit found = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            #1;
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(found), 64'd1);
        if (found) chk("done_latency", 64'(cyc - last_xfer_cyc), 64'd1);
    endtask

    task automatic wait_count(input int target, input int budget);
        bit hit = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            #1;
            if (xfer_count == target) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_count", 64'(hit), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d expected under 200000", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int rdc;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(gvalid), 64'd0);
        chk("rst_data", 64'(gdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_rd_a", 64'(rd_a), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Full dump, ready held high
        gready = 1'b1;
        @(posedge clk); #1;
        start_dump(1'b1);
        @(negedge clk);
        chk("cyc0_rd_en", 64'(rd_en), 64'd0);
        @(negedge clk);
        chk("cyc1_rd_en", 64'(rd_en), 64'd1);
        chk("cyc1_busy", 64'(busy), 64'd1);
        wait_done(5000);
        chk("full_total", 64'(xfer_count), 64'(TOTAL));
        chk("full_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("first_valid_latency", 64'(xfer_cyc[0] - start_cyc), 64'd3);
        chk("back_to_back", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd1);
        chk("row_gap", 64'(xfer_cyc[39] - xfer_cyc[38]), 64'd3);
        chk("row0_first", 64'(cap[0]), 64'h00);
        chk("row0_byte6", 64'(cap[6]), 64'h7F);
        chk("row0_last", 64'(cap[38]), 64'h00);
        chk("row3_last", 64'(cap[3*39+38]), 64'h03);
        chk("row49_last", 64'(cap[49*39+38]), 64'h01);
        chk("done_busy", 64'(busy), 64'd0);
        rdc = rd_en_count;
        repeat (10) @(posedge clk);
        #1;
        chk("no_restart_busy", 64'(busy), 64'd0);
        chk("no_restart_rd_en", 64'(rd_en_count), 64'(rdc));
        chk("done_sticky", 64'(done), 64'd1);
        readback = 1'b0;
        repeat (2) @(posedge clk);

        // Backpressure
        #1;
        rand_ready = 1'b1;
        start_dump(1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("bp_done_cleared", 64'(done), 64'd0);
        wait_done(20000);
        chk("bp_total", 64'(xfer_count), 64'(TOTAL));
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        rand_ready = 1'b0;
        @(posedge clk); #1;
        gready   = 1'b1;
        readback = 1'b0;
        repeat (2) @(posedge clk);

        // Abort at row 20, byte 10, then restart from row 0
        #1;
        start_dump(1'b1);
        wait_count(20*39 + 10, 3000);
        hold_en  = 1'b0;
        readback = 1'b0;
        gready   = 1'b0;
        @(negedge clk);
        chk("abort_pre_valid", 64'(gvalid), 64'd1);
        chk("abort_pre_data", 64'(gdata), 64'hFF);
        @(posedge clk); #1;
        chk("abort_valid", 64'(gvalid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        hold_en = 1'b1;
        gready  = 1'b1;
        start_dump(1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("restart_rd_en", 64'(rd_en), 64'd1);
        chk("restart_rd_a", 64'(rd_a), 64'd0);
        wait_done(5000);
        chk("restart_first_latency", 64'(xfer_cyc[0] - start_cyc), 64'd3);
        chk("restart_first_byte", 64'(cap[0]), 64'h00);
        chk("restart_total", 64'(xfer_count), 64'(TOTAL));
        readback = 1'b0;
        repeat (2) @(posedge clk);

        // Mode conflict: start edge while INIT=1
        #1;
        init = 1'b1;
        @(posedge clk); #1;
        readback = 1'b1;
        rdc = rd_en_count;
        repeat (10) @(posedge clk);
        #1;
        chk("init_block_busy", 64'(busy), 64'd0);
        chk("init_block_rd_en", 64'(rd_en_count), 64'(rdc));
        readback = 1'b0;
        init     = 1'b0;
        repeat (2) @(posedge clk);

        // LOAD asserted mid-dump
        #1;
        start_dump(1'b1);
        wait_count(100, 1000);
        hold_en = 1'b0;
        load    = 1'b1;
        gready  = 1'b0;
        @(posedge clk); #1;
        chk("load_abort_valid", 64'(gvalid), 64'd0);
        chk("load_abort_busy", 64'(busy), 64'd0);
        chk("load_abort_done", 64'(done), 64'd0);
        exp_q.delete();
        load     = 1'b0;
        readback = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        hold_en = 1'b1;

        // Soft RESET edge while stalled in SHIFT
        gready = 1'b0;
        start_dump(1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_before_reset", 64'(gvalid), 64'd1);
        hold_en = 1'b0;
        rst_sys = 1'b1;
        @(posedge clk); #1;
        chk("srst_valid", 64'(gvalid), 64'd0);
        chk("srst_data", 64'(gdata), 64'd0);
        chk("srst_busy", 64'(busy), 64'd0);
        chk("srst_done", 64'(done), 64'd0);
        chk("srst_rd_en", 64'(rd_en), 64'd0);
        chk("srst_rd_a", 64'(rd_a), 64'd0);
        rst_sys  = 1'b0;
        readback = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        hold_en = 1'b1;

        // Async reset in RD_WAIT
        gready = 1'b1;
        start_dump(1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rdwait_busy", 64'(busy), 64'd1);
        chk("rdwait_rd_en", 64'(rd_en), 64'd0);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_valid", 64'(gvalid), 64'd0);
        @(posedge clk); #1;
        chk("arst_hold_valid", 64'(gvalid), 64'd0);
        rstn     = 1'b1;
        readback = 1'b0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
